// File: rtl/cm_serial_feeder.sv
// Operand sequencer and result collector for one serial MAC processing element.
// Buffers a window of DEPTH (a,b) pairs, streams them into the PE, then captures the result.
//
// state  | meaning
// LOAD   | accepting operand pairs into the window buffer
// READY  | window full, waiting for start
// STREAM | issuing one buffered pair per cycle to the PE
// WAIT   | letting the PE pipeline drain for PE_LAT cycles
// RESULT | holding the captured sum until the consumer takes it
module cm_serial_feeder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 9,
  parameter int PE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_a,
  input  logic [DATA_W-1:0] load_b,
  input  logic              start,
  output logic              busy,
  output logic [DATA_W-1:0] pe_a,
  output logic [DATA_W-1:0] pe_b,
  output logic              pe_mux_reset,
  input  logic [DATA_W-1:0] pe_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data
);

  localparam int IW = $clog2(DEPTH);
  localparam int WW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

  typedef enum logic [2:0] {
    S_LOAD, S_READY, S_STREAM, S_WAIT, S_RESULT
  } state_t;

  state_t            state, state_nx;
  logic [IW-1:0]     count, count_nx;
  logic [IW-1:0]     idx, idx_nx;
  logic [WW-1:0]     wait_cnt, wait_cnt_nx;
  logic [DATA_W-1:0] buf_a [DEPTH];
  logic [DATA_W-1:0] buf_b [DEPTH];
  logic [DATA_W-1:0] pe_a_nx, pe_b_nx, res_data_nx;
  logic              pe_mux_reset_nx;
  logic              load_fire;

  assign load_ready = (state == S_LOAD);
  assign busy       = (state == S_STREAM) || (state == S_WAIT);
  assign res_valid  = (state == S_RESULT);
  assign load_fire  = load_valid && load_ready;

  always_comb begin
    state_nx        = state;
    count_nx        = count;
    idx_nx          = idx;
    wait_cnt_nx     = wait_cnt;
    res_data_nx     = res_data;
    pe_a_nx         = '0;
    pe_b_nx         = '0;
    pe_mux_reset_nx = 1'b1;
    case (state)
      S_LOAD: begin
        if (load_fire) begin
          count_nx = count + 1'b1;
          if (count == IW'(DEPTH - 1)) state_nx = S_READY;
        end
      end
      S_READY: begin
        // the first pair is registered onto the PE port on the same edge start is seen
        if (start) begin
          state_nx        = S_STREAM;
          idx_nx          = '0;
          pe_a_nx         = buf_a[0];
          pe_b_nx         = buf_b[0];
          pe_mux_reset_nx = 1'b1;
        end
      end
      S_STREAM: begin
        if (idx == IW'(DEPTH - 1)) begin
          state_nx    = S_WAIT;
          wait_cnt_nx = '0;
        end else begin
          idx_nx          = idx + 1'b1;
          pe_a_nx         = buf_a[idx + 1'b1];
          pe_b_nx         = buf_b[idx + 1'b1];
          pe_mux_reset_nx = 1'b0;
        end
      end
      S_WAIT: begin
        wait_cnt_nx = wait_cnt + 1'b1;
        if (wait_cnt == WW'(PE_LAT - 1)) begin
          res_data_nx = pe_out;
          state_nx    = S_RESULT;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          state_nx = S_LOAD;
          count_nx = '0;
        end
      end
      default: state_nx = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_LOAD;
      count        <= '0;
      idx          <= '0;
      wait_cnt     <= '0;
      res_data     <= '0;
      pe_a         <= '0;
      pe_b         <= '0;
      pe_mux_reset <= 1'b1;
    end else begin
      state        <= state_nx;
      count        <= count_nx;
      idx          <= idx_nx;
      wait_cnt     <= wait_cnt_nx;
      res_data     <= res_data_nx;
      pe_a         <= pe_a_nx;
      pe_b         <= pe_b_nx;
      pe_mux_reset <= pe_mux_reset_nx;
    end
  end

  // buffer is never cleared; a new window overwrites every entry
  always_ff @(posedge clk) begin
    if (!rst && load_fire) begin
      buf_a[count] <= load_a;
      buf_b[count] <= load_b;
    end
  end

endmodule
